// File: rtl/and_gate_checker.sv
// Scoreboard stage for a registered 2-input AND gate: rebuilds a&b through a
// delay line, compares against y each clock and records pass/fail statistics.
module and_gate_checker #(
    parameter int LATENCY      = 1,
    parameter int CNT_W        = 8,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             checking,
    output logic             halted,
    output logic             err_flag,
    output logic             err_a,
    output logic             err_b,
    output logic             err_y,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int FILL_W = $clog2(LATENCY + 1);
    localparam int DLY_W  = 3 * LATENCY;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DLY_W-1:0]  dly_push;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              err_flag_q, err_flag_d;
    logic              err_a_q, err_a_d;
    logic              err_b_q, err_b_d;
    logic              err_y_q, err_y_d;
    logic              checking_q, checking_d;
    logic              halted_q, halted_d;

    logic       push;
    logic       flush;
    logic       cmp;
    logic       miss;
    logic [2:0] tap;

    // Each entry is {a, b, a&b}; entry 0 is the newest sample.
    if (LATENCY == 1) begin : g_dly_one
        assign dly_push = {a, b, a & b};
    end else begin : g_dly_many
        assign dly_push = {dly_q[DLY_W-4:0], a, b, a & b};
    end

    assign tap  = dly_q[DLY_W-1 -: 3];
    assign miss = (y !== tap[0]);

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        push    = 1'b0;
        flush   = 1'b0;
        cmp     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FILL;
                    fill_d  = FILL_W'(1);
                    push    = 1'b1;
                end
            end
            ST_FILL: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else begin
                    push = 1'b1;
                    // The oldest entry becomes valid once LATENCY samples are in.
                    if (fill_q == FILL_LAST) begin
                        cmp     = 1'b1;
                        state_d = ST_CHECK;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else begin
                    push = 1'b1;
                    cmp  = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
                flush   = 1'b1;
            end
        endcase

        if (cmp && miss && STOP_ON_FAIL) begin
            state_d = ST_HALT;
        end
        if (flush) begin
            fill_d = '0;
        end
        if (clear) begin
            state_d = ST_IDLE;
            fill_d  = '0;
        end
    end

    always_comb begin
        dly_d = dly_q;
        if (clear || flush) begin
            dly_d = '0;
        end else if (push) begin
            dly_d = dly_push;
        end
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_flag_d = err_flag_q;
        err_a_d    = err_a_q;
        err_b_d    = err_b_q;
        err_y_d    = err_y_q;

        if (clear) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_flag_d = 1'b0;
            err_a_d    = 1'b0;
            err_b_d    = 1'b0;
            err_y_d    = 1'b0;
        end else if (cmp) begin
            if (miss) begin
                fail_cnt_d = (fail_cnt_q == CNT_MAX) ? fail_cnt_q
                                                     : fail_cnt_q + CNT_W'(1);
                err_flag_d = 1'b1;
                // Snapshot keeps only the first failing vector.
                if (!err_flag_q) begin
                    err_a_d = tap[2];
                    err_b_d = tap[1];
                    err_y_d = y;
                end
            end else begin
                pass_cnt_d = (pass_cnt_q == CNT_MAX) ? pass_cnt_q
                                                     : pass_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        checking_d = (state_d == ST_CHECK);
        halted_d   = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fill_q     <= '0;
            dly_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_flag_q <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            err_y_q    <= 1'b0;
            checking_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            dly_q      <= dly_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_flag_q <= err_flag_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            err_y_q    <= err_y_d;
            checking_q <= checking_d;
            halted_q   <= halted_d;
        end
    end

    assign checking = checking_q;
    assign halted   = halted_q;
    assign err_flag = err_flag_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign err_y    = err_y_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// Directed bench for and_gate_checker: three instances (default, stop-on-fail,
// 3-bit counters) share one modelled AND gate with a fault-injection xor.
module tb_and_gate_checker;

    logic clk;
    logic rst;
    logic en;
    logic clear;
    logic a;
    logic b;
    logic y;
    logic inj;
    logic gate_q;

    logic chk0, hlt0, err0, ea0, eb0, ey0;
    logic chk1, hlt1, err1, ea1, eb1, ey1;
    logic chk2, hlt2, err2, ea2, eb2, ey2;
    logic [7:0] pc0, fc0, pc1, fc1;
    logic [2:0] pc2, fc2;

    logic [21:0] s0, s1, e22;
    logic [11:0] s2, e12;

    int checks = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural registered AND gate; inj flips its output to plant a fault.
    always @(posedge clk) gate_q <= a & b;
    assign y = gate_q ^ inj;

    assign s0 = {chk0, hlt0, err0, ea0, eb0, ey0, pc0, fc0};
    assign s1 = {chk1, hlt1, err1, ea1, eb1, ey1, pc1, fc1};
    assign s2 = {chk2, hlt2, err2, ea2, eb2, ey2, pc2, fc2};

    and_gate_checker #(.LATENCY(1), .CNT_W(8), .STOP_ON_FAIL(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .a(a), .b(b), .y(y),
        .checking(chk0), .halted(hlt0), .err_flag(err0),
        .err_a(ea0), .err_b(eb0), .err_y(ey0),
        .pass_cnt(pc0), .fail_cnt(fc0)
    );

    and_gate_checker #(.LATENCY(1), .CNT_W(8), .STOP_ON_FAIL(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .a(a), .b(b), .y(y),
        .checking(chk1), .halted(hlt1), .err_flag(err1),
        .err_a(ea1), .err_b(eb1), .err_y(ey1),
        .pass_cnt(pc1), .fail_cnt(fc1)
    );

    and_gate_checker #(.LATENCY(1), .CNT_W(3), .STOP_ON_FAIL(1'b0)) u2 (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .a(a), .b(b), .y(y),
        .checking(chk2), .halted(hlt2), .err_flag(err2),
        .err_a(ea2), .err_b(eb2), .err_y(ey2),
        .pass_cnt(pc2), .fail_cnt(fc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clear = 1'b0;
        a = 1'b0; b = 1'b0; inj = 1'b0;
        tick(); tick();
        checks++;
        if (s0 !== 22'd0) $display("FAIL reset_u0 got %h exp %h", s0, 22'd0);
        else passed++;
        checks++;
        if (s1 !== 22'd0) $display("FAIL reset_u1 got %h exp %h", s1, 22'd0);
        else passed++;
        checks++;
        if (s2 !== 12'd0) $display("FAIL reset_u2 got %h exp %h", s2, 12'd0);
        else passed++;
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (s0 !== 22'd0) $display("FAIL idle_u0 got %h exp %h", s0, 22'd0);
        else passed++;
        checks++;
        if (s2 !== 12'd0) $display("FAIL idle_u2 got %h exp %h", s2, 12'd0);
        else passed++;
    endtask

    task automatic test_basic();
        en = 1'b1; a = 1'b0; b = 1'b0;
        tick();
        e22 = 22'd0;
        checks++;
        if (s0 !== e22) $display("FAIL basic_fill got %h exp %h", s0, e22);
        else passed++;
        a = 1'b0; b = 1'b1;
        tick();
        e22 = {6'b100000, 8'd1, 8'd0};
        checks++;
        if (s0 !== e22) $display("FAIL basic_first got %h exp %h", s0, e22);
        else passed++;
        a = 1'b1; b = 1'b0; tick();
        a = 1'b1; b = 1'b1; tick();
        a = 1'b0; b = 1'b0; tick();
        e22 = {6'b100000, 8'd4, 8'd0};
        checks++;
        if (s0 !== e22) $display("FAIL basic_four got %h exp %h", s0, e22);
        else passed++;
        en = 1'b0;
        tick();
        e22 = {6'b000000, 8'd4, 8'd0};
        checks++;
        if (s0 !== e22) $display("FAIL basic_idle got %h exp %h", s0, e22);
        else passed++;
    endtask

    task automatic test_fault_continue();
        pulse_clear();
        checks++;
        if (s0 !== 22'd0) $display("FAIL clear_u0 got %h exp %h", s0, 22'd0);
        else passed++;
        en = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        a = 1'b0; b = 1'b1; inj = 1'b1;
        tick();
        e22 = {6'b101110, 8'd0, 8'd1};
        checks++;
        if (s0 !== e22) $display("FAIL fault_first got %h exp %h", s0, e22);
        else passed++;
        inj = 1'b0; a = 1'b1; b = 1'b0;
        tick(); tick();
        e22 = {6'b101110, 8'd2, 8'd1};
        checks++;
        if (s0 !== e22) $display("FAIL fault_continue got %h exp %h", s0, e22);
        else passed++;
        inj = 1'b1;
        tick();
        e22 = {6'b101110, 8'd2, 8'd2};
        checks++;
        if (s0 !== e22) $display("FAIL fault_snapshot got %h exp %h", s0, e22);
        else passed++;
        inj = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_stop_on_fail();
        pulse_clear();
        en = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        a = 1'b0; b = 1'b1; inj = 1'b1;
        tick();
        e22 = {6'b011110, 8'd0, 8'd1};
        checks++;
        if (s1 !== e22) $display("FAIL halt_enter got %h exp %h", s1, e22);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            a = i[0]; b = i[1]; inj = (i == 2);
            tick();
        end
        inj = 1'b0;
        checks++;
        if (s1 !== e22) $display("FAIL halt_frozen got %h exp %h", s1, e22);
        else passed++;
        pulse_clear();
        checks++;
        if (s1 !== 22'd0) $display("FAIL halt_clear got %h exp %h", s1, 22'd0);
        else passed++;
        tick();
        checks++;
        if (s1 !== 22'd0) $display("FAIL halt_refill got %h exp %h", s1, 22'd0);
        else passed++;
        tick();
        e22 = {6'b100000, 8'd1, 8'd0};
        checks++;
        if (s1 !== e22) $display("FAIL halt_restart got %h exp %h", s1, e22);
        else passed++;
        en = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        pulse_clear();
        en = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            a = i[0]; b = i[1];
            tick();
        end
        e12 = {6'b100000, 3'd7, 3'd0};
        checks++;
        if (s2 !== e12) $display("FAIL sat_pass got %h exp %h", s2, e12);
        else passed++;
        e22 = {6'b100000, 8'd10, 8'd0};
        checks++;
        if (s0 !== e22) $display("FAIL sat_wide got %h exp %h", s0, e22);
        else passed++;
        inj = 1'b1;
        tick();
        e12 = {6'b101101, 3'd7, 3'd1};
        checks++;
        if (s2 !== e12) $display("FAIL sat_fail got %h exp %h", s2, e12);
        else passed++;
        inj = 1'b0;
        tick();
        checks++;
        if (s2 !== e12) $display("FAIL sat_hold got %h exp %h", s2, e12);
        else passed++;
        en = 1'b0;
        tick();
    endtask

    task automatic test_en_drop();
        pulse_clear();
        en = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        a = 1'b1; b = 1'b0;
        tick();
        en = 1'b0; a = 1'b1; b = 1'b1; inj = 1'b1;
        tick();
        e22 = {6'b000000, 8'd1, 8'd0};
        checks++;
        if (s0 !== e22) $display("FAIL drop_flush got %h exp %h", s0, e22);
        else passed++;
        inj = 1'b0; en = 1'b1; a = 1'b0; b = 1'b1;
        tick();
        checks++;
        if (s0 !== e22) $display("FAIL drop_refill got %h exp %h", s0, e22);
        else passed++;
        a = 1'b0; b = 1'b0;
        tick();
        e22 = {6'b100000, 8'd2, 8'd0};
        checks++;
        if (s0 !== e22) $display("FAIL drop_resume got %h exp %h", s0, e22);
        else passed++;
    endtask

    task automatic test_rst_clear_fail();
        inj = 1'b1; rst = 1'b1; clear = 1'b1;
        tick();
        checks++;
        if (s0 !== 22'd0) $display("FAIL rstclr_u0 got %h exp %h", s0, 22'd0);
        else passed++;
        checks++;
        if (s1 !== 22'd0) $display("FAIL rstclr_u1 got %h exp %h", s1, 22'd0);
        else passed++;
        rst = 1'b0; clear = 1'b0; inj = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (s0 !== 22'd0) $display("FAIL rst_after got %h exp %h", s0, 22'd0);
        else passed++;
        en = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        inj = 1'b1; clear = 1'b1;
        tick();
        checks++;
        if (s0 !== 22'd0) $display("FAIL clear_vs_fail got %h exp %h", s0, 22'd0);
        else passed++;
        clear = 1'b0; inj = 1'b0; en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fault_continue();
        test_stop_on_fail();
        test_saturation();
        test_en_drop();
        test_rst_clear_fail();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
